dec7seg: RTL and testbench
==========================

Name: dec7seg

Overview:
- Hex-to-seven-segment decoder for a single display digit. A 4-bit nibble becomes 8 segment drive lines: a–g plus decimal point.
- Sits between a numeric datapath (counter/register) and the board LED/7-seg pins.
- One registered output stage: glitch-free pins, 1-cycle latency, adds blanking, lamp test and polarity control.

Parameters:
- ACTIVE_LOW, 0, 0 = segment lit when bit is 1 (common cathode); 1 = all 8 output bits inverted at the output register (common anode).
- RESET_PATTERN, 8'h00, raw (pre-polarity) pattern loaded into the output register on reset; default is all segments dark.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  update enable; 0 holds the output register.
- hex  in  4  nibble to display, 0x0–0xF.
- dp  in  1  decimal-point request.
- blank  in  1  1 forces all segments, including dp, dark.
- lamp_test  in  1  1 forces all 8 segments lit.
- led  out  8  segment drive. Bit map: [7]=a [6]=b [5]=c [4]=d [3]=e [2]=f [1]=g [0]=dp.

Behaviour:
- Reset: rst_n low immediately and asynchronously sets the raw register to RESET_PATTERN. led = RESET_PATTERN, XOR 8'hFF if ACTIVE_LOW. Held until rst_n high, then first update on the next qualified edge.
- Raw glyph table, bits [7:1], active-high, hex → a..g:
  - 0 → 1111110, 1 → 0110000, 2 → 1101101, 3 → 1111001
  - 4 → 0110011, 5 → 1011011, 6 → 1011111, 7 → 1110000
  - 8 → 1111111, 9 → 1111011, A → 1110111, b → 0011111
  - c → 0001101, d → 0111101, E → 1001111, F → 1000111
- Examples: 0x0 → 8'b11111100; 0xA → 8'b11101110; 0xF → 8'b10001110 (dp=0).
- raw[0] = dp.
- Priority, highest first: lamp_test (raw = 8'hFF) > blank (raw = 8'h00) > glyph|dp.
- Register update: raw register loads the selected value on a rising clk edge with en=1. en=0 holds it, independent of the other inputs.
- Latency: led reflects inputs sampled at edge N from edge N onward (1 cycle). No combinational path from any input to led.
- Polarity: led = raw XOR {8{ACTIVE_LOW}}. Polarity is applied after the priority mux, so blank is dark and lamp_test is lit in both modes.
- Wrap-around: 0xF → 0x0 transitions decode normally; no undefined codes exist.
- Unknown input: X/Z on hex is don't-care in RTL. The verification model flags it as a "?" glyph and does not check led.

Optional Feature:
- Macro DEC7SEG_RBLANK_EN: ripple leading-zero blanking, 7447-style.
- Defined, adds two ports:
  - rbi (in, 1): ripple-blank input from the more-significant digit; 1 means the digits above were blanked zeros.
  - rbo (out, 1): registered ripple-blank output.
- Defined, behaviour:
  - When rbi=1 and hex=0 and dp=0 and lamp_test=0, the digit is loaded as blank (raw=8'h00) and rbo=1.
  - Otherwise rbo=0.
  - rbo resets to 0 and shares the en and latency rules of led.
  - For an N-digit display, tie the most-significant digit's rbi to 1; the least-significant digit ties rbi to 0 so "0" still shows.
- Undefined: no rbi/rbo ports; behaviour exactly as above.

Test Plan:
- Reset: assert rst_n=0 mid-cycle → led=8'h00 immediately (ACTIVE_LOW=0), 8'hFF with ACTIVE_LOW=1; release, hex=0, en=1 → 8'b11111100 after the next edge.
- Full sweep: en=1, dp=0, step hex 0x0..0xF once per cycle, then wrap to 0x0 → each led matches the glyph table one cycle later; 0xF→0x0 gives 8'b10001110 then 8'b11111100.
- dp/blank/lamp_test priority: hex=8, dp=1 → 8'hFF; blank=1 → 8'h00; blank=1 with lamp_test=1 → 8'hFF; hex=1, dp=1 → 8'b01100001.
- Enable hold: load hex=3 (8'b11110010), drop en, drive hex=7 for 5 cycles → led stays 8'b11110010; raise en → 8'b11100000 next edge.
- ACTIVE_LOW=1 sweep: hex=4 → led=8'b10011001; blank=1 → 8'hFF.
- DEC7SEG_RBLANK_EN: two-digit chain, MSD rbi=1:
  - value 0x05 → MSD led=8'h00, MSD rbo=1, LSD 8'b10110110.
  - value 0x00 with LSD rbi=0 → LSD shows 8'b11111100.
  - value 0x50 → MSD shows 8'b10110110, MSD rbo=0.

Source files
------------

// File: rtl/dec7seg_if.sv
// dec7seg_if: segment-decoder bus (update enable, nibble, display controls, segment drive).
// When DEC7SEG_RBLANK_EN is defined the bus also carries the ripple-blank pair rbi/rbo.
interface dec7seg_if;
    logic       en;
    logic [3:0] hex;
    logic       dp;
    logic       blank;
    logic       lamp_test;
    logic [7:0] led;
`ifdef DEC7SEG_RBLANK_EN
    logic       rbi;
    logic       rbo;

    modport master (
        output en, hex, dp, blank, lamp_test, rbi,
        input  led, rbo
    );

    modport slave (
        input  en, hex, dp, blank, lamp_test, rbi,
        output led, rbo
    );
`else
    modport master (
        output en, hex, dp, blank, lamp_test,
        input  led
    );

    modport slave (
        input  en, hex, dp, blank, lamp_test,
        output led
    );
`endif
endinterface

// File: rtl/dec7seg.sv
// dec7seg: hex nibble to seven-segment decoder with one registered output stage.
// Bit map of led: [7]=a [6]=b [5]=c [4]=d [3]=e [2]=f [1]=g [0]=dp.
// Priority: lamp_test (all lit) > blank (all dark) > glyph|dp.
// Optional ripple leading-zero blanking is built when DEC7SEG_RBLANK_EN is defined.
module dec7seg #(
    parameter bit         ACTIVE_LOW    = 1'b0,
    parameter logic [7:0] RESET_PATTERN = 8'h00
) (
    input logic      clk,
    input logic      rst_n,
    dec7seg_if.slave bus
);

    // Polarity is folded into the register input so the pins come straight from flops.
    localparam logic [7:0] POL_MASK = {8{ACTIVE_LOW}};

    logic [6:0] glyph;
    logic [7:0] raw_d;
    logic [7:0] led_d;
    logic [7:0] led_q;
`ifdef DEC7SEG_RBLANK_EN
    logic       rbo_d;
    logic       rbo_q;
`endif

    // Active-high a..g pattern for the current nibble.
    always_comb begin
        glyph = '0;
        case (bus.hex)
            4'h0: glyph = 7'b1111110;
            4'h1: glyph = 7'b0110000;
            4'h2: glyph = 7'b1101101;
            4'h3: glyph = 7'b1111001;
            4'h4: glyph = 7'b0110011;
            4'h5: glyph = 7'b1011011;
            4'h6: glyph = 7'b1011111;
            4'h7: glyph = 7'b1110000;
            4'h8: glyph = 7'b1111111;
            4'h9: glyph = 7'b1111011;
            4'hA: glyph = 7'b1110111;
            4'hB: glyph = 7'b0011111;
            4'hC: glyph = 7'b0001101;
            4'hD: glyph = 7'b0111101;
            4'hE: glyph = 7'b1001111;
            4'hF: glyph = 7'b1000111;
            default: glyph = '0;
        endcase
    end

`ifdef DEC7SEG_RBLANK_EN
    // A zero without dp under a blanked higher digit is a leading zero; lamp test overrides it.
    always_comb begin
        rbo_d = bus.rbi & (bus.hex == 4'h0) & ~bus.dp & ~bus.lamp_test;
    end
`endif

    // Priority select of the raw (active-high) segment pattern.
    always_comb begin
        raw_d = {glyph, bus.dp};
        if (bus.lamp_test) begin
            raw_d = '1;
        end else if (bus.blank) begin
            raw_d = '0;
        end
`ifdef DEC7SEG_RBLANK_EN
        else if (rbo_d) begin
            raw_d = '0;
        end
`endif
    end

    assign led_d = raw_d ^ POL_MASK;

    // Output register: async reset to the polarity-adjusted reset pattern, loads only when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q <= RESET_PATTERN ^ POL_MASK;
        end else if (bus.en) begin
            led_q <= led_d;
        end
    end

    assign bus.led = led_q;

`ifdef DEC7SEG_RBLANK_EN
    // Ripple-blank output follows the same enable and latency as the segment register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rbo_q <= 1'b0;
        end else if (bus.en) begin
            rbo_q <= rbo_d;
        end
    end

    assign bus.rbo = rbo_q;
`endif

endmodule

// File: tb/tb_dec7seg.sv
// tb_dec7seg: directed and randomized checks of dec7seg in both polarities,
// plus a two-digit ripple-blank chain when DEC7SEG_RBLANK_EN is defined.
module tb_dec7seg;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic       en, dp, blank, lt;
    logic [3:0] hex;

    int unsigned total = 0;
    int unsigned bad   = 0;

    dec7seg_if u_if_h ();
    dec7seg_if u_if_l ();

    assign u_if_h.en = en;  assign u_if_h.hex = hex;  assign u_if_h.dp = dp;
    assign u_if_h.blank = blank;  assign u_if_h.lamp_test = lt;
    assign u_if_l.en = en;  assign u_if_l.hex = hex;  assign u_if_l.dp = dp;
    assign u_if_l.blank = blank;  assign u_if_l.lamp_test = lt;

    dec7seg #(.ACTIVE_LOW(1'b0), .RESET_PATTERN(8'h00)) u_dut_h (
        .clk(clk), .rst_n(rst_n), .bus(u_if_h.slave)
    );
    dec7seg #(.ACTIVE_LOW(1'b1), .RESET_PATTERN(8'h00)) u_dut_l (
        .clk(clk), .rst_n(rst_n), .bus(u_if_l.slave)
    );

`ifdef DEC7SEG_RBLANK_EN
    logic [3:0] hex_msd, hex_lsd;
    dec7seg_if u_if_m ();
    dec7seg_if u_if_s ();

    assign u_if_h.rbi = 1'b0;
    assign u_if_l.rbi = 1'b0;
    assign u_if_m.en = en;  assign u_if_m.hex = hex_msd;  assign u_if_m.dp = dp;
    assign u_if_m.blank = blank;  assign u_if_m.lamp_test = lt;  assign u_if_m.rbi = 1'b1;
    assign u_if_s.en = en;  assign u_if_s.hex = hex_lsd;  assign u_if_s.dp = dp;
    assign u_if_s.blank = blank;  assign u_if_s.lamp_test = lt;  assign u_if_s.rbi = 1'b0;

    dec7seg #(.ACTIVE_LOW(1'b0), .RESET_PATTERN(8'h00)) u_dut_m (
        .clk(clk), .rst_n(rst_n), .bus(u_if_m.slave)
    );
    dec7seg #(.ACTIVE_LOW(1'b0), .RESET_PATTERN(8'h00)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .bus(u_if_s.slave)
    );

    logic [7:0] exp_m, exp_s;
    logic       exp_rbo_m;
`endif

    // Reference glyph table, a..g active-high, indexed by nibble.
    logic [6:0] GLYPH [16];
    initial begin
        GLYPH = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                  7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                  7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                  7'b0001101, 7'b0111101, 7'b1001111, 7'b1000111};
    end

    function automatic logic [7:0] ref_raw(input logic [3:0] h, input logic d,
                                           input logic b, input logic l, input logic r);
        if (l) return 8'hFF;
        if (b) return 8'h00;
        if (r && h == 4'h0 && !d) return 8'h00;
        return {GLYPH[h], d};
    endfunction

    logic [7:0] exp_raw;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // Advance one clock edge, updating the reference state with the inputs sampled at that edge.
    task automatic tick();
        @(posedge clk);
        if (en) begin
            exp_raw = ref_raw(hex, dp, blank, lt, 1'b0);
`ifdef DEC7SEG_RBLANK_EN
            exp_m     = ref_raw(hex_msd, dp, blank, lt, 1'b1);
            exp_s     = ref_raw(hex_lsd, dp, blank, lt, 1'b0);
            exp_rbo_m = (hex_msd == 4'h0) && !dp && !lt;
`endif
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_hi"}, u_if_h.led, exp_raw);
        check({tag, "_lo"}, u_if_l.led, exp_raw ^ 8'hFF);
`ifdef DEC7SEG_RBLANK_EN
        check({tag, "_msd"}, u_if_m.led, exp_m);
        check({tag, "_lsd"}, u_if_s.led, exp_s);
        check({tag, "_rbo_msd"}, {7'b0, u_if_m.rbo}, {7'b0, exp_rbo_m});
        check({tag, "_rbo_lsd"}, {7'b0, u_if_s.rbo}, 8'h00);
`endif
    endtask

    task automatic do_reset_model();
        exp_raw = 8'h00;
`ifdef DEC7SEG_RBLANK_EN
        exp_m = 8'h00;  exp_s = 8'h00;  exp_rbo_m = 1'b0;
`endif
    endtask

    initial begin
        en = 1'b0;  hex = 4'h0;  dp = 1'b0;  blank = 1'b0;  lt = 1'b0;
`ifdef DEC7SEG_RBLANK_EN
        hex_msd = 4'h0;  hex_lsd = 4'h0;
`endif
        do_reset_model();
        #1 rst_n = 1'b0;
        #1;
        check("reset_hi", u_if_h.led, 8'h00);
        check("reset_lo", u_if_l.led, 8'hFF);
        #10 rst_n = 1'b1;

        en = 1'b1;  hex = 4'h0;
        tick();
        check("first_update", u_if_h.led, 8'b11111100);

        for (int i = 0; i <= 16; i++) begin
            hex = 4'(i);
            tick();
            check_model("sweep");
            if (i == 15) check("sweep_F", u_if_h.led, 8'b10001110);
            if (i == 16) check("wrap_0", u_if_h.led, 8'b11111100);
        end

        hex = 4'h8;  dp = 1'b1;  tick();  check("eight_dp", u_if_h.led, 8'hFF);
        blank = 1'b1;            tick();  check("blank", u_if_h.led, 8'h00);
        lt = 1'b1;               tick();  check("lt_over_blank", u_if_h.led, 8'hFF);
        check("lt_lo", u_if_l.led, 8'h00);
        lt = 1'b0;  blank = 1'b0;  hex = 4'h1;
        tick();  check("one_dp", u_if_h.led, 8'b01100001);
        dp = 1'b0;

        hex = 4'h3;  tick();  check("load3", u_if_h.led, 8'b11110010);
        en = 1'b0;  hex = 4'h7;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold", u_if_h.led, 8'b11110010);
        end
        en = 1'b1;  tick();  check("resume7", u_if_h.led, 8'b11100000);

        hex = 4'h4;  tick();  check("lo_four", u_if_l.led, 8'b10011001);
        blank = 1'b1;  tick();
        check("lo_blank", u_if_l.led, 8'hFF);
        check("hi_blank", u_if_h.led, 8'h00);
        blank = 1'b0;

        hex = 4'h8;  tick();
        #2 rst_n = 1'b0;
        #1;
        do_reset_model();
        check("async_reset_hi", u_if_h.led, 8'h00);
        check("async_reset_lo", u_if_l.led, 8'hFF);
        @(negedge clk) rst_n = 1'b1;
        tick();
        check_model("after_reset");

`ifdef DEC7SEG_RBLANK_EN
        hex_msd = 4'h0;  hex_lsd = 4'h5;  tick();
        check("rb05_msd", u_if_m.led, 8'h00);
        check("rb05_rbo", {7'b0, u_if_m.rbo}, 8'h01);
        check("rb05_lsd", u_if_s.led, 8'b10110110);
        hex_lsd = 4'h0;  tick();
        check("rb00_lsd", u_if_s.led, 8'b11111100);
        hex_msd = 4'h5;  tick();
        check("rb50_msd", u_if_m.led, 8'b10110110);
        check("rb50_rbo", {7'b0, u_if_m.rbo}, 8'h00);
`endif

        for (int i = 0; i < 300; i++) begin
            en    = ($urandom_range(0, 3) != 0);
            hex   = 4'($urandom);
            dp    = 1'($urandom);
            blank = ($urandom_range(0, 7) == 0);
            lt    = ($urandom_range(0, 7) == 0);
`ifdef DEC7SEG_RBLANK_EN
            hex_msd = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            hex_lsd = 4'($urandom);
`endif
            tick();
            check_model("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
